// File: rtl/cnn_pkg.sv
// Shared definitions for the result readout path: default widths, the
// reader state encoding and the read-credit helper.
package cnn_pkg;

    localparam int RR_ADDR_W = 7;
    localparam int RR_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rr_state_e;

    // A new read may issue only if the words already sitting in the output
    // buffer (net of a word leaving this cycle) plus the read whose data is
    // arriving this cycle leave room for it. Counting the departing word lets
    // a continuously ready consumer receive one word per cycle.
    function automatic logic rr_credit_ok(input logic full, input logic empty,
                                          input logic pop, input logic pend);
        logic [1:0] occ;
        if (full) begin
            occ = 2'd2;
        end else if (empty) begin
            occ = 2'd0;
        end else begin
            occ = 2'd1;
        end
        if (pop) begin
            occ = occ - 2'd1;
        end else begin
            occ = occ;
        end
        return (occ + {1'b0, pend}) < 2'd2;
    endfunction

endpackage

// File: rtl/result_reader_if.sv
// Control, result-memory and output-stream signals of the result reader.
// Optional macro RESULT_READER_LAST_EN adds the out_last stream marker.
interface result_reader_if #(
    parameter int ADDR_W = cnn_pkg::RR_ADDR_W,
    parameter int DATA_W = cnn_pkg::RR_DATA_W
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] len;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;
`ifdef RESULT_READER_LAST_EN
    logic              out_last;
`endif

    // Host / memory / consumer side
    modport master (
        output start, base_addr, len, mem_rdata, out_ready,
        input  mem_rd, mem_addr, out_valid, out_data, busy, done
`ifdef RESULT_READER_LAST_EN
        , input out_last
`endif
    );

    // Reader side
    modport slave (
        input  start, base_addr, len, mem_rdata, out_ready,
        output mem_rd, mem_addr, out_valid, out_data, busy, done
`ifdef RESULT_READER_LAST_EN
        , output out_last
`endif
    );
endinterface

// File: rtl/result_skid_fifo.sv
// Two-entry output buffer with registered data, valid and full/empty flags.
// Entry "head" is the word presented downstream; "tail" holds a second word.
module result_skid_fifo
    import cnn_pkg::*;
#(
    parameter int DATA_W = RR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              pop_s;
    logic              push_s;

    // Next buffer contents for every push/pop combination
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        pop_s  = pop & (cnt_q != 2'd0);
        push_s = push & ((cnt_q != 2'd2) | pop_s);
        case ({push_s, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
        valid_d = (cnt_d != 2'd0);
        full_d  = (cnt_d == 2'd2);
        empty_d = (cnt_d == 2'd0);
    end

    // Buffer storage and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = head_q;
    assign full      = full_q;
    assign empty     = empty_q;

endmodule

// File: rtl/result_reader.sv
// Streams len result words starting at base_addr out of the result memory.
// Reads are issued only against free buffer credit, so every read in flight
// always has a slot to land in. Optional macro RESULT_READER_LAST_EN drives
// out_last on the final word of a transfer.
module result_reader
    import cnn_pkg::*;
#(
    parameter int ADDR_W = RR_ADDR_W,
    parameter int DATA_W = RR_DATA_W
) (
    input logic            clk,
    input logic            rst,
    result_reader_if.slave bus
);

    rr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              fifo_valid_s;
    logic [DATA_W-1:0] fifo_data_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              pop_s;
    logic              mem_rd_s;

    assign pop_s    = fifo_valid_s & bus.out_ready;
    assign mem_rd_s = (state_q == READ) && (rd_cnt_q != len_q) &&
                      rr_credit_ok(fifo_full_s, fifo_empty_s, pop_s, rd_pend_q);

    // Data returned by the read issued last cycle is pushed into the buffer
    result_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend_q),
        .push_data (bus.mem_rdata),
        .pop       (pop_s),
        .out_valid (fifo_valid_s),
        .out_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Next state, address/word counters and done pulse
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = pop_s ? (out_cnt_q + ADDR_W'(1)) : out_cnt_q;
        rd_pend_d = mem_rd_s;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d    = bus.base_addr;
                    len_d     = bus.len;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                    if (bus.len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (mem_rd_s) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                    if (rd_cnt_q == (len_q - ADDR_W'(1))) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    state_d = READ;
                end
            end
            DRAIN: begin
                if (pop_s && (out_cnt_q == (len_q - ADDR_W'(1)))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Reader state, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
            rd_pend_q <= rd_pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.mem_rd    = mem_rd_s;
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = fifo_valid_s;
    assign bus.out_data  = fifo_data_s;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef RESULT_READER_LAST_EN
    assign bus.out_last  = fifo_valid_s & (out_cnt_q == (len_q - ADDR_W'(1)));
`endif

endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: stimulus pushes expected addresses and
// words into queues; a monitor pops and compares on every read and handshake.
module tb_result_reader;

    localparam int AW = 7;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    result_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    result_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // result memory: data = address * 3, one cycle after the read strobe
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= DW'(bus.mem_addr) * 32'd3;
    end

    exp_t        dq[$];
    logic [AW-1:0] aq[$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, iss_cnt = 0, hs_cnt = 0, rd_total = 0, ov_total = 0;
    bit pat_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // out_ready pattern 1,0,0,1 while enabled
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (pat_en) begin
                bus.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
                k++;
            end
        end
    end

    // monitor: reads, handshakes, stall stability, credit bound
    initial begin
        bit            hs;
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        exp_t          e;
        int            outst;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
                iss_cnt    = 0;
                hs_cnt     = 0;
            end else begin
                hs = bus.out_valid && bus.out_ready;
                if (bus.out_valid) ov_total++;
                if (prev_stall) begin
                    chk("stall_valid", 64'(bus.out_valid), 64'(1));
                    chk("stall_data", 64'(bus.out_data), 64'(prev_data));
                end
                if (bus.mem_rd) begin
                    rd_total++;
                    outst = iss_cnt - hs_cnt - int'(hs);
                    chk("credit_over", 64'(outst > 1), 64'(0));
                    if (aq.size() == 0) flag("extra_read");
                    else chk("mem_addr", 64'(bus.mem_addr), 64'(aq.pop_front()));
                    iss_cnt++;
                end
                if (hs) begin
                    if (dq.size() == 0) flag("extra_word");
                    else begin
                        e = dq.pop_front();
                        chk("out_data", 64'(bus.out_data), 64'(e.data));
                        if (e.cyc >= 0) chk("out_cycle", 64'(cyc), 64'(e.cyc));
`ifdef RESULT_READER_LAST_EN
                        chk("out_last", 64'(bus.out_last), 64'(e.last));
`endif
                    end
                    hs_cnt++;
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
        end
    end

    task automatic start_xfer(input int base, input int n, input bit timed, output int t0);
        exp_t e;
        int   a;
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = AW'(base);
        bus.len       = AW'(n);
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            a = (base + i) % 128;
            aq.push_back(AW'(a));
            e.data = DW'(a * 3);
            e.cyc  = timed ? (t0 + 3 + i) : -1;
            e.last = (i == n - 1);
            dq.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int dcyc);
        bit got;
        got  = 1'b0;
        dcyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got  = 1'b1;
                dcyc = cyc;
                break;
            end
        end
        if (!got) flag({nm, "_done_timeout"});
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_mem_rd"}, 64'(bus.mem_rd), 64'(0));
        chk({nm, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
        chk({nm, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        chk({nm, "_out_data"}, 64'(bus.out_data), 64'(0));
        chk({nm, "_busy"}, 64'(bus.busy), 64'(0));
        chk({nm, "_done"}, 64'(bus.done), 64'(0));
`ifdef RESULT_READER_LAST_EN
        chk({nm, "_out_last"}, 64'(bus.out_last), 64'(0));
`endif
    endtask

    initial begin
        int t0, dcyc, r0, o0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;

        // basic transfer with exact timing
        start_xfer(10, 4, 1'b1, t0);
        chk("t1_busy", 64'(bus.busy), 64'(1));
        wait_done("t1", dcyc);
        chk("t1_done_cycle", 64'(dcyc), 64'(t0 + 7));
        @(negedge clk);
        chk("t1_done_pulse", 64'(bus.done), 64'(0));
        chk("t1_words_left", 64'(dq.size()), 64'(0));

        // empty transfer
        r0 = rd_total;
        o0 = ov_total;
        start_xfer(5, 0, 1'b0, t0);
        wait_done("t2", dcyc);
        chk("t2_done_cycle", 64'(dcyc), 64'(t0 + 1));
        repeat (4) @(negedge clk);
        chk("t2_no_reads", 64'(rd_total - r0), 64'(0));
        chk("t2_no_valid", 64'(ov_total - o0), 64'(0));

        // address wrap
        start_xfer(126, 4, 1'b0, t0);
        wait_done("t3", dcyc);
        chk("t3_addrs_left", 64'(aq.size()), 64'(0));
        chk("t3_words_left", 64'(dq.size()), 64'(0));

        // backpressure
        pat_en = 1'b1;
        start_xfer(20, 8, 1'b0, t0);
        wait_done("t4", dcyc);
        pat_en = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        chk("t4_words_left", 64'(dq.size()), 64'(0));

        // start while busy is ignored
        start_xfer(40, 5, 1'b0, t0);
        repeat (2) @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = AW'(0);
        bus.len       = AW'(2);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("t5", dcyc);
        repeat (3) @(negedge clk);
        chk("t5_busy_after", 64'(bus.busy), 64'(0));
        chk("t5_addrs_left", 64'(aq.size()), 64'(0));
        chk("t5_words_left", 64'(dq.size()), 64'(0));

        // reset mid-transfer
        start_xfer(50, 6, 1'b0, t0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t6_pre_valid", 64'(bus.out_valid), 64'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;
        aq.delete();
        dq.delete();
        chk_reset_outputs("t6_reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_stale_ignored", 64'(bus.out_valid), 64'(0));
        start_xfer(60, 2, 1'b0, t0);
        wait_done("t6", dcyc);
        repeat (3) @(negedge clk);
        chk("t6_words_left", 64'(dq.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
